spi_peripheral: RTL

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-3 register-access target.
//
// A 16-bit frame, MSB first, carries {rw, addr[6:0], data[7:0]}.
// - rw = 0 (write): the data byte is presented on reg_wdata with a one-clk
//   reg_we strobe.
// - rw = 1 (read): reg_re strobes after the instruction byte, and reg_rdata
//   is shifted out on miso during the data byte.
// All SPI inputs are oversampled by clk through SYNC_STAGES-deep
// synchronizers.
//
// Register strobe protocol (no back-pressure):
// - reg_we is a one-clk pulse; reg_addr and reg_wdata are valid while it is
//   high.
// - reg_re is a one-clk pulse with reg_addr valid.
// - The register file must present reg_rdata two clk later; it is sampled
//   exactly once.
//
// Optional feature (macro SPI_PERIPHERAL_FRAME_ERR_EN): adds frame_err and
// frame_err_cnt, which report frames aborted by cs_n rising early.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   sclk           SPI clock (idles high)
//   cs_n           SPI chip select, active low
//   mosi           SPI data in
//   miso           SPI data out (0 whenever miso_oe = 0)
//   miso_oe        output enable for the sdio pad
//   reg_addr       register address from the instruction byte
//   reg_wdata      write data from the data byte
//   reg_we         one-clk write strobe
//   reg_re         one-clk read strobe
//   reg_rdata      read data, valid 2 clk after reg_re
//   fsm_state      current FSM state (0 IDLE, 1 INSTR, 2 DATA, 3 WAIT_CS)
//   frame_err      (optional) one-clk pulse per aborted frame
//   frame_err_cnt  (optional) saturating count of aborted frames
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [1:0] fsm_state
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
  ,
  output logic       frame_err,
  output logic [7:0] frame_err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INSTR   = 2'd1,
    DATA    = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

  // Synchronizers plus one delay register per edge-detected signal.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [2:0]             fill_cnt;
  logic                   sync_ok;

  state_t     state;
  state_t     state_nx;
  logic [3:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] frame_byte;
  logic       rw_q;
  logic       re_d;
  logic       tx_armed;
  logic [7:0] tx_sr;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_bit;
  logic in_frame;
  logic instr_done;
  logic data_done;
  logic abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
      fill_cnt  <= 3'd0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      if (fill_cnt != FILL_DONE) begin
        fill_cnt <= fill_cnt + 3'd1;
      end
    end
  end

  // Edges are trusted only once the chain holds real samples.
  // This stops the reset value of the cs_n chain from producing a
  // false falling edge when cs_n is already low at reset release.
  assign sync_ok   = (fill_cnt == FILL_DONE);
  assign sclk_rise = sync_ok &  sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = sync_ok & ~sclk_sync[SYNC_STAGES-1] &  sclk_d;
  assign cs_rise   = sync_ok &  cs_sync[SYNC_STAGES-1]   & ~cs_d;
  assign cs_fall   = sync_ok & ~cs_sync[SYNC_STAGES-1]   &  cs_d;
  // The mosi chain has the same depth as the sclk chain, so the bit read
  // here is the one present at the sclk rising edge.
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  assign in_frame   = (state == INSTR) || (state == DATA);
  assign frame_byte = {shift_q[6:0], mosi_bit};
  assign instr_done = (state == INSTR) && !cs_rise && sclk_rise && (bit_cnt == 4'd7);
  assign data_done  = (state == DATA)  && !cs_rise && sclk_rise && (bit_cnt == 4'd15);
  assign abort      = cs_rise && in_frame;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs_fall) state_nx = INSTR;
      INSTR:   if (cs_rise) state_nx = IDLE;
               else if (instr_done) state_nx = DATA;
      DATA:    if (cs_rise) state_nx = IDLE;
               else if (data_done) state_nx = WAIT_CS;
      WAIT_CS: if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 4'd0;
      shift_q   <= 8'd0;
      rw_q      <= 1'b0;
      reg_addr  <= 7'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      re_d      <= 1'b0;
      tx_armed  <= 1'b0;
      tx_sr     <= 8'd0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_d   <= reg_re;

      if (state == IDLE && cs_fall) begin
        bit_cnt  <= 4'd0;
        tx_armed <= 1'b0;
      end

      if (in_frame && sclk_rise && !cs_rise) begin
        shift_q <= frame_byte;
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (instr_done) begin
        reg_addr <= frame_byte[6:0];
        rw_q     <= frame_byte[7];
        reg_re   <= frame_byte[7];
      end

      if (data_done && !rw_q) begin
        reg_wdata <= frame_byte;
        reg_we    <= 1'b1;
      end

      // Read data arrives two clk after reg_re and is only loaded while
      // the frame that asked for it is still in its data phase.
      if (re_d && state == DATA) begin
        tx_sr    <= reg_rdata;
        tx_armed <= 1'b1;
      end

      // The first falling edge after the load enables the pad and shows
      // bit7. Falls in WAIT_CS are ignored, so bit0 is held to the end.
      if (sclk_fall && state == DATA && tx_armed) begin
        miso_oe <= 1'b1;
        miso    <= tx_sr[7];
        tx_sr   <= {tx_sr[6:0], 1'b0};
      end

      // cs_n rising ends every frame and takes priority over sclk activity.
      if (cs_rise) begin
        miso_oe  <= 1'b0;
        miso     <= 1'b0;
        tx_armed <= 1'b0;
      end
    end
  end

`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err     <= 1'b0;
      frame_err_cnt <= 8'd0;
    end else begin
      frame_err <= abort;
      if (abort && frame_err_cnt != 8'hFF) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule
